// File: rtl/ram_stream_out_pkg.sv
// Constants and types shared by the pixel pipeline stages.
// The RAM geometry and default frame size are common to every stage.
package ram_stream_out_pkg;

    localparam int AW_DEF     = 17;
    localparam int DW_DEF     = 24;
    localparam int NPIX_DEF   = 76800;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The output FIFO must cover every read in flight plus the head word and one
    // slot of slack, so that issuing stays continuous while iREADY is high.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/ram_stream_out_if.sv
// RAM read port and output stream of the readout stage, grouped with the sequencer handshake.
interface ram_stream_out_if
    import ram_stream_out_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          ena;
    logic          done;
    logic [DW-1:0] oDataA;
    logic          wrenA;
    logic [AW-1:0] iAddrA;
    logic          iREADY;
    logic          oDVAL;
    logic [DW-1:0] oDATA;
    logic          oBUSY;

    modport master (
        input  ena, oDataA, iREADY,
        output done, wrenA, iAddrA, oDVAL, oDATA, oBUSY
    );

    modport slave (
        output ena, oDataA, iREADY,
        input  done, wrenA, iAddrA, oDVAL, oDATA, oBUSY
    );

endinterface

// File: rtl/ram_stream_out_fifo.sv
// Small output FIFO with a registered head word; push and pop may occur in the same cycle.
// A push into an empty FIFO is visible on head/valid one cycle later (no bypass).
module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 24,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (cnt_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (!push && do_pop) cnt_d = cnt_q - 1'b1;
        // The head copy tracks whichever word becomes the new front entry.
        if (push && ((cnt_q == '0) || (do_pop && cnt_q == CW'(1)))) head_d = wdata;
        else if (do_pop && cnt_q > CW'(1)) head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && cnt_q == CW'(DEPTH)));

    assign head  = head_q;
    assign valid = (cnt_q != '0);
    assign count = cnt_q;

endmodule

// File: rtl/ram_stream_out.sv
// Readout stage: on ena, reads NPIX words from the pixel RAM in address order and
// streams them downstream with backpressure, raising done after the last transfer.
module ram_stream_out
    import ram_stream_out_pkg::*;
#(
    parameter int NPIX   = NPIX_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    ram_stream_out_if.master     bus
);

    localparam int DEPTH = fifo_depth(RD_LAT);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [AW:0] NPIX_C = (AW + 1)'(NPIX);
    localparam logic [AW:0] LAST_C = NPIX_C - 1'b1;

    state_t            state_q, state_d;
    logic [AW:0]       issue_cnt_q, issue_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              done_q, done_d;

    logic              issue;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       used;
    logic              credit_ok;
    logic              fifo_vld;
    logic [DW-1:0]     fifo_head;
    logic              pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
    end

    // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
    assign used      = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign credit_ok = (used < (CW + 1)'(DEPTH));
    assign pop       = fifo_vld && bus.iREADY;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        addr_d      = addr_q;
        done_d      = done_q;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.ena) begin
                    state_d     = ST_RUN;
                    done_d      = 1'b0;
                    issue_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if ((issue_cnt_q < NPIX_C) && credit_ok) begin
                    issue       = 1'b1;
                    addr_d      = issue_cnt_q[AW-1:0];
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_C) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish on the edge that retires the final word.
                if ((inflight == '0) &&
                    ((fifo_cnt == '0) || (fifo_cnt == CW'(1) && pop))) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            addr_q      <= '0;
            vld_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            addr_q      <= addr_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
        end
    end

    stream_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_fifo (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .push  (vld_q[RD_LAT-1]),
        .wdata (bus.oDataA),
        .pop   (pop),
        .head  (fifo_head),
        .valid (fifo_vld),
        .count (fifo_cnt)
    );

    assign bus.iAddrA = addr_d;
    assign bus.wrenA  = 1'b0;
    assign bus.done   = done_q;
    assign bus.oDVAL  = fifo_vld;
    assign bus.oDATA  = fifo_head;
    assign bus.oBUSY  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_ram_stream_out.sv
// Bench for ram_stream_out: three frame sizes sharing one clock, each with a
// two-cycle behavioural RAM holding mem[a] = a*3.
module tb_ram_stream_out;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    ram_stream_out_if #(.AW(17), .DW(24)) b8  ();
    ram_stream_out_if #(.AW(17), .DW(24)) b1  ();
    ram_stream_out_if #(.AW(4),  .DW(24)) b16 ();

    ram_stream_out #(.NPIX(8),  .AW(17), .DW(24), .RD_LAT(2)) u8  (.iCLK(clk), .iRST_N(rst_n), .bus(b8.master));
    ram_stream_out #(.NPIX(1),  .AW(17), .DW(24), .RD_LAT(2)) u1  (.iCLK(clk), .iRST_N(rst_n), .bus(b1.master));
    ram_stream_out #(.NPIX(16), .AW(4),  .DW(24), .RD_LAT(2)) u16 (.iCLK(clk), .iRST_N(rst_n), .bus(b16.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] a8_p, a1_p;
    logic [3:0]  a16_p;
    always @(posedge clk) begin
        a8_p       <= b8.iAddrA;
        b8.oDataA  <= 24'(32'(a8_p) * 3);
        a1_p       <= b1.iAddrA;
        b1.oDataA  <= 24'(32'(a1_p) * 3);
        a16_p      <= b16.iAddrA;
        b16.oDataA <= 24'(32'(a16_p) * 3);
    end

    logic [23:0] got8[$], got1[$], got16[$];
    int          max1, max16;
    bit          wren_seen;
    bit          hold_pending;
    logic [23:0] hold_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending) begin
                chk("hold_dval", 32'(b8.oDVAL), 32'd1);
                chk("hold_data", 32'(b8.oDATA), 32'(hold_data));
            end
            if (b8.oDVAL && b8.iREADY)   got8.push_back(b8.oDATA);
            if (b1.oDVAL && b1.iREADY)   got1.push_back(b1.oDATA);
            if (b16.oDVAL && b16.iREADY) got16.push_back(b16.oDATA);
            if (int'(b1.iAddrA) > max1)   max1  = int'(b1.iAddrA);
            if (int'(b16.iAddrA) > max16) max16 = int'(b16.iAddrA);
            if (b8.wrenA || b1.wrenA || b16.wrenA) wren_seen = 1'b1;
            hold_pending = b8.oDVAL && !b8.iREADY;
            hold_data    = b8.oDATA;
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-exact frame on the NPIX=8 instance with iREADY held high.
    task automatic t1_frame(input string tag, input bit repulse);
        b8.iREADY = 1'b1;
        b8.ena    = 1'b1;
        chk({tag, "_dval_c0"}, 32'(b8.oDVAL), 32'd0);
        tick();
        for (int cyc = 1; cyc <= 13; cyc++) begin
            b8.ena = repulse && (cyc == 2 || cyc == 6);
            chk($sformatf("%s_dval_c%0d", tag, cyc), 32'(b8.oDVAL), 32'(cyc >= 4 && cyc <= 11));
            if (cyc >= 4 && cyc <= 11)
                chk($sformatf("%s_data_c%0d", tag, cyc), 32'(b8.oDATA), 32'((cyc - 4) * 3));
            chk($sformatf("%s_done_c%0d", tag, cyc), 32'(b8.done), 32'(cyc >= 12));
            chk($sformatf("%s_busy_c%0d", tag, cyc), 32'(b8.oBUSY), 32'(cyc <= 11));
            if (cyc == 1) chk({tag, "_addr_first"}, 32'(b8.iAddrA), 32'd0);
            if (cyc == 8 || cyc == 13) chk({tag, "_addr_last"}, 32'(b8.iAddrA), 32'd7);
            tick();
        end
        b8.ena = 1'b0;
    endtask

    // Frame on the NPIX=8 instance under a ready pattern, compared against the
    // ordered word list the RAM contents imply. mode 0: toggle, 1: random, 2: long stall.
    task automatic frame8(input string tag, input int mode);
        logic [23:0] expq[$];
        int          cyc;
        for (int a = 0; a < 8; a++) expq.push_back(24'(a * 3));
        got8.delete();
        b8.iREADY = (mode != 2);
        b8.ena    = 1'b1;
        tick();
        b8.ena = 1'b0;
        cyc = 0;
        while (!b8.done && cyc < 400) begin
            case (mode)
                0:       b8.iREADY = cyc[0];
                1:       b8.iREADY = ($urandom_range(0, 3) != 0);
                default: b8.iREADY = (cyc >= 20);
            endcase
            if (mode == 2 && cyc == 20) begin
                chk({tag, "_stall_reads"}, 32'(b8.iAddrA <= 17'd3), 32'd1);
                chk({tag, "_stall_dval"}, 32'(b8.oDVAL), 32'd1);
                chk({tag, "_stall_head"}, 32'(b8.oDATA), 32'd0);
                chk({tag, "_stall_xfers"}, 32'(got8.size()), 32'd0);
            end
            tick();
            cyc++;
        end
        b8.iREADY = 1'b1;
        chk({tag, "_done"}, 32'(b8.done), 32'd1);
        chk({tag, "_count"}, 32'(got8.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got8.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 32'(got8[i]), 32'(expq[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n      = 1'b0;
        b8.ena     = 1'b0;  b8.iREADY  = 1'b0;
        b1.ena     = 1'b0;  b1.iREADY  = 1'b1;
        b16.ena    = 1'b0;  b16.iREADY = 1'b1;
        wren_seen  = 1'b0;
        hold_pending = 1'b0;
        max1 = 0; max16 = 0;
        repeat (2) tick();
        chk("rst_done",  32'(b8.done),   32'd0);
        chk("rst_dval",  32'(b8.oDVAL),  32'd0);
        chk("rst_data",  32'(b8.oDATA),  32'd0);
        chk("rst_addr",  32'(b8.iAddrA), 32'd0);
        chk("rst_wren",  32'(b8.wrenA),  32'd0);
        chk("rst_busy",  32'(b8.oBUSY),  32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        t1_frame("t1", 1'b0);
        frame8("t2", 0);
        frame8("t3", 2);
        for (int r = 0; r < 3; r++) frame8($sformatf("rnd%0d", r), 1);

        for (int r = 0; r < 2; r++) begin
            got1.delete();
            max1 = 0;
            b1.ena = 1'b1;
            tick();
            b1.ena = 1'b0;
            cyc = 0;
            while (!b1.done && cyc < 50) begin tick(); cyc++; end
            chk($sformatf("t4_done%0d", r),  32'(b1.done),     32'd1);
            chk($sformatf("t4_count%0d", r), 32'(got1.size()), 32'd1);
            if (got1.size() > 0) chk($sformatf("t4_word%0d", r), 32'(got1[0]), 32'd0);
            chk($sformatf("t4_maxaddr%0d", r), 32'(max1), 32'd0);
            chk($sformatf("t4_busy%0d", r), 32'(b1.oBUSY), 32'd0);
        end

        t1_frame("t5", 1'b1);
        b8.ena = 1'b1;
        tick();
        b8.ena = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("t5r_done", 32'(b8.done),   32'd0);
        chk("t5r_dval", 32'(b8.oDVAL),  32'd0);
        chk("t5r_data", 32'(b8.oDATA),  32'd0);
        chk("t5r_addr", 32'(b8.iAddrA), 32'd0);
        chk("t5r_busy", 32'(b8.oBUSY),  32'd0);
        tick();
        rst_n = 1'b1;
        got8.delete();
        repeat (6) tick();
        chk("t5r_stale_xfers", 32'(got8.size()), 32'd0);
        chk("t5r_idle_dval",   32'(b8.oDVAL),    32'd0);
        t1_frame("t5c", 1'b0);

        got16.delete();
        max16 = 0;
        b16.ena = 1'b1;
        tick();
        b16.ena = 1'b0;
        cyc = 0;
        while (!b16.done && cyc < 100) begin tick(); cyc++; end
        chk("t6_done",    32'(b16.done),     32'd1);
        chk("t6_count",   32'(got16.size()), 32'd16);
        for (int i = 0; i < 16 && i < got16.size(); i++)
            chk($sformatf("t6_word%0d", i), 32'(got16[i]), 32'(i * 3));
        chk("t6_maxaddr", 32'(max16),        32'd15);
        chk("t6_addr",    32'(b16.iAddrA),   32'd15);

        chk("wren_never", 32'(wren_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
